mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The parameter WAIT_CYCLES SHALL default to 2 and set the number of stall cycles between request acceptance and array access (legal range 0-15).
REQ-002 The parameter DEPTH_WORDS SHALL default to 256 and set the number of 32-bit words in the array.
REQ-003 clk  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  the initiator presents a request.
REQ-006 req_ready  output  1  the responder accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load or fetch.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, lane-aligned.
REQ-010 req_be  input  4  store byte enables; bit i covers bits [8i+7:8i].
REQ-011 rsp_valid  output  1  a response is presented.
REQ-012 rsp_ready  input  1  the initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP: IDLE->WAIT on accept if WAIT_CYCLES>0, else IDLE->ACCESS; WAIT->ACCESS when the counter reaches 0; ACCESS->RESP unconditionally; RESP->IDLE on rsp_valid && rsp_ready.
REQ-016 req_ready SHALL be 1 only in IDLE, so at most one transaction is outstanding.
REQ-017 On accept (req_valid && req_ready), the block SHALL register write, addr, wdata and be, and SHALL load the wait counter with WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement once per cycle; WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-019 rsp_valid SHALL first assert WAIT_CYCLES+2 cycles after the accept edge (4 cycles with the default).
REQ-020 An error is flagged if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; on error there SHALL be no array write, rsp_rdata = 0 and rsp_err = 1.
REQ-021 A store SHALL update, at the ACCESS edge, only the lanes whose be bit is set; be = 4'b0000 is a legal no-op with rsp_err = 0.
REQ-022 A load SHALL return the full word held at the ACCESS edge; req_be SHALL be ignored for loads.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until the handshake and SHALL drop in the cycle after it.
REQ-024 Request inputs SHALL be ignored outside IDLE.
REQ-025 Backpressure of any length on rsp_ready SHALL neither lose nor duplicate a response.

Reset
REQ-026 While reset = 0: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0, and req_ready = 0.
REQ-027 req_ready SHALL assert in the first cycle after reset deasserts.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 If reset asserts in WAIT, the pending store SHALL be dropped with no array write; if it asserts in RESP, the response SHALL be discarded.

Structure
REQ-030 The state encoding, WORD_BYTES = 4 and the error-check widths SHALL live in the shared package riscv_pkg.
REQ-031 The byte-enabled storage SHALL be a sub-module sram_sp (one port, synchronous write, combinational read), instantiated once.

Verification
REQ-032 Reset release -> req_ready = 1 in the next cycle; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-033 Store 0xDEADBEEF to 0x10 with be = 4'hF, then load 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, and rsp_valid rises 4 cycles after each accept.
REQ-034 Store 0x11223344 to 0x10 with be = 4'b0101, then load -> rsp_rdata = 0xDE22BE44.
REQ-035 Load 0x13, then store to 0x400 with DEPTH_WORDS = 256 -> both return rsp_err = 1 and rsp_rdata = 0; a following load of word 0x100 is still rejected, and the array is unchanged.
REQ-036 Hold rsp_ready = 0 for 10 cycles on a load -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; the handshake then returns the FSM to IDLE.
REQ-037 Store 0xCAFEF00D to 0x20 with reset asserted during WAIT, then load 0x20 after release -> rsp_rdata equals the prior contents of 0x20, not 0xCAFEF00D.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory responder: FSM encoding, word geometry
// and the address error check used on request acceptance.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int WORD_BYTES = 4;
   localparam int OFFSET_W   = $clog2(WORD_BYTES);
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // A request is rejected when it is not word aligned or its word index
   // falls beyond the end of the array.
   function automatic logic addr_error(input logic [XLEN-1:0] addr,
                                       input int unsigned     depth_words);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[OFFSET_W-1:0] != '0);
      out_of_range = ({{OFFSET_W{1'b0}}, addr[XLEN-1:OFFSET_W]} >= depth_words);
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port word array with per-byte write enables, synchronous write and
// combinational read.
module sram_sp
   import riscv_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [AW-1:0]         addr,
   input  logic [XLEN-1:0]       wdata,
   output logic [XLEN-1:0]       rdata
);

   // NOTE: the array has no reset; clearing it would cost a write port per
   // word and its contents are defined only by stores.
   logic [XLEN-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, stalls a fixed
// number of cycles, accesses the array, then holds the response until taken.
module mem_responder
   import riscv_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [XLEN-1:0]       req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   input  logic [WORD_BYTES-1:0] req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rsp_rdata,
   output logic                  rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  write_q;
   logic [AW-1:0]         idx_q;
   logic [XLEN-1:0]       wdata_q;
   logic [WORD_BYTES-1:0] be_q;
   logic                  err_q;
   logic [XLEN-1:0]       rdata_hold_q;
   logic [XLEN-1:0]       mem_rdata;
   logic                  mem_we;
   logic                  accept;
   logic                  rsp_done;

   // Ready is gated by reset so it stays low for the whole reset interval.
   assign req_ready = (state_q == IDLE) && reset;
   assign accept    = req_valid && req_ready;
   assign rsp_done  = rsp_valid && rsp_ready;
   assign mem_we    = (state_q == ACCESS) && write_q && !err_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: state_d takes its hold value first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         WAIT:    if (cnt_q == '0) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (rsp_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         write_q      <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         err_q        <= 1'b0;
         rdata_hold_q <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[AW+OFFSET_W-1:OFFSET_W];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= addr_error(req_addr, DEPTH_WORDS);
            cnt_q   <= CNT_INIT;
         end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         // Stores and rejected requests always answer with zero data.
         if (state_q == ACCESS) begin
            rdata_hold_q <= (write_q || err_q) ? '0 : mem_rdata;
         end

         // The response registers load one cycle into RESP and clear right
         // after the handshake, so they only ever carry a live response.
         if (state_q == RESP) begin
            if (rsp_done) begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end else if (!rsp_valid) begin
               rsp_valid <= 1'b1;
               rsp_rdata <= rdata_hold_q;
               rsp_err   <= err_q;
            end
         end
      end
   end

   sram_sp #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .be    (be_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, reset corner
// sequences and randomized traffic against a word-array reference model.
module tb_mem_responder;

   localparam int WAIT_CYCLES = 2;
   localparam int DEPTH_WORDS = 256;
   localparam int TIMEOUT     = 60;
   localparam int N_VECS      = 16;
   localparam int N_RANDOM    = 200;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_mem [DEPTH_WORDS];

   mem_responder #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: byte-addressed rules applied to a plain word array.
   task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
      err   = (addr % 4 != 0) || (addr / 4 >= DEPTH_WORDS);
      rdata = '0;
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) model_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            rdata = model_mem[addr / 4];
         end
      end
   endtask

   // Presents a request and returns at the falling edge after the accept edge.
   task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic keep_busy, output logic ok);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      n = 0;
      while (!req_ready && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", req_ready, 1);
      ok = req_ready;
      if (!ok) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      // Junk requests while busy must be ignored.
      req_valid = keep_busy;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
   endtask

   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rdata, output logic err);
      logic ok;
      logic stable;
      logic busy_low;
      int   cycles;
      rdata = '0;
      err   = 1'b0;
      start_req(wr, addr, wdata, be, 1'b1, ok);
      if (!ok) return;
      cycles   = 1;
      busy_low = 1'b1;
      while (!rsp_valid && cycles < TIMEOUT) begin
         if (req_ready) busy_low = 1'b0;
         @(negedge clk);
         cycles++;
      end
      check("rsp_arrives", rsp_valid, 1);
      if (!rsp_valid) begin
         req_valid = 1'b0;
         return;
      end
      check("rsp_latency", cycles - 1, WAIT_CYCLES + 2);
      rdata  = rsp_rdata;
      err    = rsp_err;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (req_ready || !rsp_valid || rsp_rdata !== rdata || rsp_err !== err) stable = 1'b0;
         @(negedge clk);
      end
      if (req_ready || !rsp_valid || rsp_rdata !== rdata || rsp_err !== err) stable = 1'b0;
      check("busy_ready_low", busy_low, 1);
      check("rsp_hold_stable", stable, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("rsp_drop", {rsp_valid, rsp_err, rsp_rdata}, 0);
      check("ready_after_rsp", req_ready, 1);
   endtask

   task automatic txn_vs_model(input string name, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int hold);
      logic [31:0] rd;
      logic [31:0] exp_rd;
      logic        e;
      logic        exp_e;
      run_txn(wr, addr, wdata, be, hold, rd, e);
      model_apply(wr, addr, wdata, be, exp_rd, exp_e);
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_err"}, e, exp_e);
   endtask

   initial begin
      vec_t        vecs [N_VECS];
      logic [31:0] rd;
      logic [31:0] mrd;
      logic        e;
      logic        me;
      logic        ok;
      logic        saw;
      logic [31:0] addr;
      int          n;
      int          sel;

      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0,  32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,  32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 0,  32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1,  32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 0,  32'hDE22_BE44, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 2,  32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 0,  32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 0,  32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 0,  32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 0,  32'h0BAD_F00D, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0,  32'h0000_0000, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h3, 10, 32'hDE22_BE44, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 0,  32'h0000_0000, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 0,  32'hA5A5_A5A5, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_03FE, 32'h0000_0000, 4'hF, 0,  32'h0000_0000, 1'b1};
      vecs[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 3,  32'h0000_0000, 1'b1};

      reset     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
      reset = 1'b1;
      #1;
      check("ready_after_release", req_ready, 1);
      @(negedge clk);
      check("idle_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, {3'b100, 32'h0});

      for (int i = 0; i < N_VECS; i++) begin
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, e);
         model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, mrd, me);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      end

      // Reset during WAIT drops the pending store.
      txn_vs_model("prior_0x20", 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0);
      start_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, ok);
      reset = 1'b0;
      #1;
      check("reset_in_wait_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("ready_after_wait_reset", req_ready, 1);
      run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, e);
      check("dropped_store_rdata", rd, 32'h1234_5678);
      check("dropped_store_err", e, 0);

      // Reset during RESP discards the pending response.
      start_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, ok);
      n = 0;
      while (!rsp_valid && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("resp_reached", rsp_valid, 1);
      reset = 1'b0;
      #1;
      check("reset_in_resp_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
      @(negedge clk);
      reset     = 1'b1;
      rsp_ready = 1'b1;
      saw       = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      rsp_ready = 1'b0;
      check("no_stale_response", saw, 0);
      check("idle_after_resp_reset", req_ready, 1);

      // Randomized traffic over a small window so loads hit known data.
      for (int w = 0; w < 16; w++) begin
         txn_vs_model("prefill", 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      end
      for (int i = 0; i < N_RANDOM; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       addr = 32'($urandom_range(0, 15) * 4);
         else if (sel == 8) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else               addr = ($urandom | 32'h0000_0400) & ~32'h3;
         txn_vs_model($sformatf("rnd%0d", i), 1'($urandom), addr, $urandom, 4'($urandom),
                      int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
